id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//   ID->EX pipeline register and operand selection for the RV32I pipeline. Latches one decoded
//   instruction per cycle, resolves RAW hazards by forwarding from MEM and WB, and drives the
//   ALU's alu_func / alu_din_a / alu_din_b directly. It also carries the control fields that
//   travel on to EX/MEM.
// PARAMETERS
//   XLEN       32      datapath width; fixed at 32 for RV32I
//   RESET_PC   32'h0   value held on ex_pc during reset
// PORTS
//   clk           in   1     clock, rising edge
//   rst           in   1     asynchronous reset, active high
//   stall         in   1     hold the current EX contents
//   flush         in   1     replace the EX contents with a bubble
//   id_valid      in   1     ID holds a real instruction
//   id_pc         in   32    PC of the ID instruction
//   id_rs1_addr   in   5     source register 1 index
//   id_rs2_addr   in   5     source register 2 index
//   id_rs1_data   in   32    register-file read data for rs1
//   id_rs2_data   in   32    register-file read data for rs2
//   id_imm        in   32    sign-extended immediate
//   id_rd_addr    in   5     destination register index
//   id_reg_we     in   1     instruction writes rd
//   id_alu_func   in   4     ALU opcode (ADD=0000 ... DINB=0111)
//   id_src_a_sel  in   2     operand A source: 00 rs1, 01 pc, 10 zero, 11 zero
//   id_src_b_sel  in   1     operand B source: 0 rs2, 1 imm
//   mem_fwd_we    in   1     MEM-stage instruction writes a register
//   mem_fwd_rd    in   5     MEM-stage destination index
//   mem_fwd_data  in   32    MEM-stage result
//   wb_fwd_we     in   1     WB-stage register write enable
//   wb_fwd_rd     in   5     WB-stage destination index
//   wb_fwd_data   in   32    WB-stage write data
//   ex_valid      out  1     EX holds a real instruction
//   ex_pc         out  32    registered PC
//   ex_rd_addr    out  5     registered rd
//   ex_reg_we     out  1     registered id_reg_we, gated with ex_valid
//   alu_func      out  4     registered ALU opcode
//   alu_din_a     out  32    forwarded and selected operand A
//   alu_din_b     out  32    forwarded and selected operand B
//   ex_store_data out  32    forwarded rs2 value, independent of id_src_b_sel
// BEHAVIOUR
//   - Reset (async, rst=1): all stored fields clear to 0 and ex_pc to RESET_PC.
//     ex_valid=0, ex_reg_we=0, alu_func=ADD, alu_din_a=0, alu_din_b=0, ex_store_data=0.
//   - Per-edge update priority, highest first:
//       1. flush: valid<=0, reg_we<=0, alu_func<=ADD, rd<=0. Flush beats stall.
//       2. stall: all fields held, subject to the operand refresh below.
//       3. otherwise: load all id_* fields; valid<=id_valid.
//   - Latency: one cycle. An instruction presented in ID at edge N appears on the outputs
//     after edge N.
//   - Capture bypass: on load, if wb_fwd_we=1 and wb_fwd_rd!=0 and wb_fwd_rd==id_rsX_addr,
//     the stored rsX value is wb_fwd_data instead of id_rsX_data.
//   - Operand refresh: while stalled and not flushed, a WB write that matches a stored rsX
//     index (index != 0) overwrites the stored rsX value. Held operands therefore never go
//     stale.
//   - Combinational forwarding on the stored rs1 and rs2:
//       priority MEM > WB > stored value;
//       a source matches only if its we=1, its rd equals the stored index, and the index != 0.
//     x0 is never forwarded, so rs index 0 always yields the stored value (0 from the regfile).
//   - Operand selection:
//       alu_din_a = fwd_rs1 / ex_pc / 0 according to src_a_sel;
//       alu_din_b = fwd_rs2 / imm according to src_b_sel;
//       ex_store_data = fwd_rs2 always.
//   - Bubble (valid=0): ex_reg_we is forced to 0. Operand outputs may still toggle, but
//     downstream stages must ignore them.
//   - Assertion of rst mid-stall or mid-flush returns the block to the reset state
//     immediately; no partial update.
// TESTING
//   1. Reset: rst=1 with arbitrary inputs -> ex_valid=0, ex_reg_we=0, alu_func=0000,
//      alu_din_a=alu_din_b=0, ex_pc=RESET_PC.
//   2. Pass-through: load rs1=5 (data 10), imm=3, src_b_sel=1, ADD, no forwarding
//      -> next cycle alu_din_a=10, alu_din_b=3, ex_valid=1.
//   3. Forward priority: stored rs1=7; mem_fwd(rd=7, data=0xAAAA) and wb_fwd(rd=7, data=0xBBBB)
//      both active -> alu_din_a=0xAAAA. Drop mem_fwd_we -> alu_din_a=0xBBBB.
//   4. x0 guard: stored rs2=0 with mem_fwd_rd=0, mem_fwd_we=1, data=0x1234
//      -> alu_din_b (src_b_sel=0)=0 and ex_store_data=0.
//   5. Stall refresh: load rs1=9 with data 1; stall=1; WB writes x9=0x55; release WB
//      -> alu_din_a=0x55 while still stalled, and fields held across 3 stall cycles.
//   6. Flush vs stall: stall=1 and flush=1 on the same edge -> ex_valid=0, ex_reg_we=0,
//      alu_func=ADD. Reset asserted mid-stall -> immediate reset values.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID->EX pipeline register with MEM/WB forwarding and ALU operand selection
module id_ex_stage #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rd_addr,
    input  logic            id_reg_we,
    input  logic [3:0]      id_alu_func,
    input  logic [1:0]      id_src_a_sel,
    input  logic            id_src_b_sel,
    input  logic            mem_fwd_we,
    input  logic [4:0]      mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_fwd_we,
    input  logic [4:0]      wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd_addr,
    output logic            ex_reg_we,
    output logic [3:0]      alu_func,
    output logic [XLEN-1:0] alu_din_a,
    output logic [XLEN-1:0] alu_din_b,
    output logic [XLEN-1:0] ex_store_data
);

    localparam logic [3:0] ALU_ADD = 4'b0000;

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [4:0]      rs1_addr_q;
    logic [4:0]      rs2_addr_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] imm_q;
    logic [4:0]      rd_q;
    logic            reg_we_q;
    logic [3:0]      func_q;
    logic [1:0]      src_a_sel_q;
    logic            src_b_sel_q;

    logic wb_hit_id_rs1, wb_hit_id_rs2, wb_hit_q_rs1, wb_hit_q_rs2;

    assign wb_hit_id_rs1 = wb_fwd_we && (wb_fwd_rd != 5'd0) && (wb_fwd_rd == id_rs1_addr);
    assign wb_hit_id_rs2 = wb_fwd_we && (wb_fwd_rd != 5'd0) && (wb_fwd_rd == id_rs2_addr);
    assign wb_hit_q_rs1  = wb_fwd_we && (wb_fwd_rd != 5'd0) && (wb_fwd_rd == rs1_addr_q);
    assign wb_hit_q_rs2  = wb_fwd_we && (wb_fwd_rd != 5'd0) && (wb_fwd_rd == rs2_addr_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= RESET_PC[XLEN-1:0];
            rs1_addr_q  <= 5'd0;
            rs2_addr_q  <= 5'd0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            rd_q        <= 5'd0;
            reg_we_q    <= 1'b0;
            func_q      <= ALU_ADD;
            src_a_sel_q <= 2'b00;
            src_b_sel_q <= 1'b0;
        end else if (flush) begin
            valid_q  <= 1'b0;
            reg_we_q <= 1'b0;
            func_q   <= ALU_ADD;
            rd_q     <= 5'd0;
        end else if (stall) begin
            // Held operands absorb WB writes so they are current when the stall releases.
            if (wb_hit_q_rs1) rs1_q <= wb_fwd_data;
            if (wb_hit_q_rs2) rs2_q <= wb_fwd_data;
        end else begin
            valid_q     <= id_valid;
            pc_q        <= id_pc;
            rs1_addr_q  <= id_rs1_addr;
            rs2_addr_q  <= id_rs2_addr;
            rs1_q       <= wb_hit_id_rs1 ? wb_fwd_data : id_rs1_data;
            rs2_q       <= wb_hit_id_rs2 ? wb_fwd_data : id_rs2_data;
            imm_q       <= id_imm;
            rd_q        <= id_rd_addr;
            reg_we_q    <= id_reg_we;
            func_q      <= id_alu_func;
            src_a_sel_q <= id_src_a_sel;
            src_b_sel_q <= id_src_b_sel;
        end
    end

    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    // MEM is younger than WB, so it wins when both target the same register.
    always_comb begin
        fwd_rs1 = rs1_q;
        if (mem_fwd_we && (mem_fwd_rd != 5'd0) && (mem_fwd_rd == rs1_addr_q))
            fwd_rs1 = mem_fwd_data;
        else if (wb_hit_q_rs1)
            fwd_rs1 = wb_fwd_data;
    end

    always_comb begin
        fwd_rs2 = rs2_q;
        if (mem_fwd_we && (mem_fwd_rd != 5'd0) && (mem_fwd_rd == rs2_addr_q))
            fwd_rs2 = mem_fwd_data;
        else if (wb_hit_q_rs2)
            fwd_rs2 = wb_fwd_data;
    end

    always_comb begin
        alu_din_a = '0;
        case (src_a_sel_q)
            2'b00:   alu_din_a = fwd_rs1;
            2'b01:   alu_din_a = pc_q;
            default: alu_din_a = '0;
        endcase
    end

    assign alu_din_b     = src_b_sel_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_rd_addr    = rd_q;
    assign ex_reg_we     = reg_we_q & valid_q;
    assign alu_func      = func_q;

endmodule
